// File: rtl/lcd_pkg.sv
// Shared constants, command classes, mode flags and cursor stepping for the
// HD44780-style LCD responder.
package lcd_pkg;

  localparam logic [6:0] LINE0_BASE = 7'h00;
  localparam logic [6:0] LINE1_BASE = 7'h40;
  localparam logic [7:0] BLANK_CHAR = 8'h20;

  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_ENTRY   = 8'h04;
  localparam logic [7:0] CMD_DISPLAY = 8'h08;
  localparam logic [7:0] CMD_SHIFT   = 8'h10;
  localparam logic [7:0] CMD_FUNC    = 8'h20;
  localparam logic [7:0] CMD_CGRAM   = 8'h40;
  localparam logic [7:0] CMD_DDRAM   = 8'h80;

  typedef enum logic [3:0] {
    K_NONE, K_CLEAR, K_HOME, K_ENTRY, K_DISPLAY, K_SHIFT, K_FUNC, K_CGRAM, K_DDRAM
  } cmd_kind_t;

  typedef enum logic {PH_HIGH, PH_LOW} phase_t;

  typedef struct packed {
    logic four_bit;
    logic two_line;
    logic disp_on;
    logic cursor_on;
    logic blink_on;
    logic incr;
  } lcd_flags_t;

  localparam lcd_flags_t FLAGS_RESET = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  // Commands are classified by their most significant set bit.
  function automatic cmd_kind_t decode_cmd(input logic [7:0] b);
    cmd_kind_t k;
    if      ((b & CMD_DDRAM)   != 8'h00) k = K_DDRAM;
    else if ((b & CMD_CGRAM)   != 8'h00) k = K_CGRAM;
    else if ((b & CMD_FUNC)    != 8'h00) k = K_FUNC;
    else if ((b & CMD_SHIFT)   != 8'h00) k = K_SHIFT;
    else if ((b & CMD_DISPLAY) != 8'h00) k = K_DISPLAY;
    else if ((b & CMD_ENTRY)   != 8'h00) k = K_ENTRY;
    else if ((b & CMD_HOME)    != 8'h00) k = K_HOME;
    else if ((b & CMD_CLEAR)   != 8'h00) k = K_CLEAR;
    else                                 k = K_NONE;
    return k;
  endfunction

  // Columns 0..15 on two lines; stepping past either end of a line hops to the other line.
  function automatic logic [6:0] step_addr(input logic line, input logic [3:0] col,
                                           input logic inc);
    logic       nline;
    logic [3:0] ncol;
    nline = line;
    if (inc) begin
      if (col == 4'hF) nline = ~line;
      ncol = col + 4'd1;
    end else begin
      if (col == 4'h0) nline = ~line;
      ncol = col - 4'd1;
    end
    return (nline ? LINE1_BASE : LINE0_BASE) | {3'b000, ncol};
  endfunction

endpackage

// File: rtl/lcd_responder_if.sv
// Parallel HD44780 bus as seen between an LCD driver and the responder.
interface lcd_responder_if;
  logic       en;
  logic       rs;
  logic [3:0] data;

  modport master (output en, rs, data);
  modport slave  (input  en, rs, data);
endinterface

// File: rtl/lcd_resp_nibble.sv
// Strobe detection and nibble-to-byte assembly for the LCD responder.
// LCD_RESPONDER_SYNC_EN: route en/rs/data through a two-flop synchronizer first.
//
// state   | meaning
// PH_HIGH | next accepted 4-bit strobe carries the high nibble
// PH_LOW  | high nibble held, next accepted strobe completes the byte
module lcd_resp_nibble
  import lcd_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  lcd_responder_if.slave    bus,
  input  logic              hold,
  input  logic              four_bit,
  input  logic              phase_clr,
  output logic              strobe_err,
  output logic              byte_done,
  output logic              byte_rs,
  output logic [7:0]        byte_data
);

  logic       en_s;
  logic       rs_s;
  logic [3:0] data_s;
  logic       en_q;
  logic       strobe;
  logic       take_hi;
  logic [3:0] hi_nib;
  phase_t     phase;
  phase_t     phase_nxt;

`ifdef LCD_RESPONDER_SYNC_EN
  logic [5:0] sync1;
  logic [5:0] sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {bus.en, bus.rs, bus.data};
      sync2 <= sync1;
    end
  end

  assign {en_s, rs_s, data_s} = sync2;
`else
  assign en_s   = bus.en;
  assign rs_s   = bus.rs;
  assign data_s = bus.data;
`endif

  assign strobe = en_q & ~en_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q   <= 1'b0;
      hi_nib <= 4'h0;
      phase  <= PH_HIGH;
    end else begin
      en_q  <= en_s;
      phase <= phase_clr ? PH_HIGH : phase_nxt;
      if (take_hi) hi_nib <= data_s;
    end
  end

  always_comb begin
    strobe_err = 1'b0;
    byte_done  = 1'b0;
    byte_rs    = rs_s;
    byte_data  = {data_s, 4'h0};
    take_hi    = 1'b0;
    phase_nxt  = phase;
    if (strobe) begin
      if (hold) begin
        strobe_err = 1'b1;
      end else if (!four_bit) begin
        byte_done = 1'b1;
      end else begin
        case (phase)
          PH_HIGH: begin
            take_hi   = 1'b1;
            phase_nxt = PH_LOW;
          end
          PH_LOW: begin
            byte_done = 1'b1;
            byte_data = {hi_nib, data_s};
            phase_nxt = PH_HIGH;
          end
          default: phase_nxt = PH_HIGH;
        endcase
      end
    end
  end

endmodule

// File: rtl/lcd_responder.sv
// HD44780-compatible LCD model: command decode, 2x16 DDRAM, busy and power-up timers.
// LCD_RESPONDER_SYNC_EN (in lcd_resp_nibble) adds two cycles of input synchronization.
module lcd_responder
  import lcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES = 40,
  parameter int unsigned CLEAR_BUSY     = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  lcd_responder_if.slave bus,
  input  logic [4:0]     rd_addr,
  output logic [7:0]     rd_data,
  output logic [6:0]     cursor_addr,
  output logic           four_bit,
  output logic           two_line,
  output logic           disp_on,
  output logic           cursor_on,
  output logic           blink_on,
  output logic           busy,
  output logic           byte_valid,
  output logic           byte_rs,
  output logic [7:0]     byte_data,
  output logic           err_timing,
  output logic           err_busy,
  output logic           err_addr
);

  localparam int PU_W   = $clog2(POWERUP_CYCLES + 2);
  localparam int BUSY_W = $clog2(CLEAR_BUSY + 2);

  logic [PU_W-1:0]   pu_cnt;
  logic [BUSY_W-1:0] busy_cnt;
  lcd_flags_t        flags;
  lcd_flags_t        flags_nxt;
  logic [6:0]        cursor_nxt;
  logic [7:0]        ddram [32];
  logic              hold;
  logic              strobe_err;
  logic              nb_done;
  logic              nb_rs;
  logic [7:0]        nb_data;
  logic              accept;
  logic              wr_en;
  logic              clr_all;
  logic              busy_load;
  logic              addr_err;
  logic              phase_clr;
  cmd_kind_t         kind;
  logic [4:0]        wr_idx;

  lcd_resp_nibble u_nibble (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .hold       (hold),
    .four_bit   (flags.four_bit),
    .phase_clr  (phase_clr),
    .strobe_err (strobe_err),
    .byte_done  (nb_done),
    .byte_rs    (nb_rs),
    .byte_data  (nb_data)
  );

  assign hold      = (pu_cnt != '0);
  assign busy      = (busy_cnt != '0);
  assign four_bit  = flags.four_bit;
  assign two_line  = flags.two_line;
  assign disp_on   = flags.disp_on;
  assign cursor_on = flags.cursor_on;
  assign blink_on  = flags.blink_on;
  assign wr_idx    = {cursor_addr[6], cursor_addr[3:0]};
  assign accept    = nb_done & ~busy;
  assign kind      = decode_cmd(nb_data);

  always_comb begin
    flags_nxt  = flags;
    cursor_nxt = cursor_addr;
    wr_en      = 1'b0;
    clr_all    = 1'b0;
    busy_load  = 1'b0;
    addr_err   = 1'b0;
    phase_clr  = 1'b0;
    if (accept) begin
      if (nb_rs) begin
        wr_en      = 1'b1;
        cursor_nxt = step_addr(cursor_addr[6], cursor_addr[3:0], flags.incr);
      end else begin
        case (kind)
          K_CLEAR: begin
            clr_all        = 1'b1;
            busy_load      = 1'b1;
            cursor_nxt     = LINE0_BASE;
            flags_nxt.incr = 1'b1;
          end
          K_HOME:    cursor_nxt = LINE0_BASE;
          K_ENTRY:   flags_nxt.incr = nb_data[1];
          K_DISPLAY: {flags_nxt.disp_on, flags_nxt.cursor_on, flags_nxt.blink_on} = nb_data[2:0];
          K_SHIFT: begin
            if (!nb_data[3]) cursor_nxt = step_addr(cursor_addr[6], cursor_addr[3:0], nb_data[2]);
          end
          K_FUNC: begin
            flags_nxt.four_bit = ~nb_data[4];
            flags_nxt.two_line = nb_data[3];
            phase_clr          = (~nb_data[4] != flags.four_bit);
          end
          K_DDRAM: begin
            // Only columns 0..15 exist; out-of-range columns fold onto them.
            cursor_nxt = {nb_data[6], 2'b00, nb_data[3:0]};
            addr_err   = (nb_data[5:4] != 2'b00);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags       <= FLAGS_RESET;
      cursor_addr <= LINE0_BASE;
      pu_cnt      <= PU_W'(POWERUP_CYCLES);
      busy_cnt    <= '0;
      byte_valid  <= 1'b0;
      byte_rs     <= 1'b0;
      byte_data   <= 8'h00;
      err_timing  <= 1'b0;
      err_busy    <= 1'b0;
      err_addr    <= 1'b0;
      rd_data     <= 8'h00;
      for (int i = 0; i < 32; i++) ddram[i] <= BLANK_CHAR;
    end else begin
      flags       <= flags_nxt;
      cursor_addr <= cursor_nxt;
      byte_valid  <= nb_done;
      err_timing  <= strobe_err;
      err_busy    <= nb_done & busy;
      err_addr    <= addr_err;
      rd_data     <= ddram[rd_addr];
      if (nb_done) begin
        byte_rs   <= nb_rs;
        byte_data <= nb_data;
      end
      if (hold) pu_cnt <= pu_cnt - PU_W'(1);
      if (busy_load)  busy_cnt <= BUSY_W'(CLEAR_BUSY);
      else if (busy)  busy_cnt <= busy_cnt - BUSY_W'(1);
      if (clr_all) begin
        for (int i = 0; i < 32; i++) ddram[i] <= BLANK_CHAR;
      end else if (wr_en) begin
        ddram[wr_idx] <= nb_data;
      end
    end
  end

endmodule

// File: tb/tb_lcd_responder.sv
// Self-checking bench for lcd_responder against a character-level LCD model.
module tb_lcd_responder;

  localparam int PU = 40;
  localparam int CB = 4;
`ifdef LCD_RESPONDER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic [6:0] cursor_addr;
  logic       four_bit, two_line, disp_on, cursor_on, blink_on, busy;
  logic       byte_valid, byte_rs;
  logic [7:0] byte_data;
  logic       err_timing, err_busy, err_addr;

  lcd_responder_if bus();

  lcd_responder #(.POWERUP_CYCLES(PU), .CLEAR_BUSY(CB)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .rd_addr(rd_addr), .rd_data(rd_data),
    .cursor_addr(cursor_addr), .four_bit(four_bit), .two_line(two_line),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on), .busy(busy),
    .byte_valid(byte_valid), .byte_rs(byte_rs), .byte_data(byte_data),
    .err_timing(err_timing), .err_busy(err_busy), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Character-level model of the display.
  logic [7:0] m_cells [32];
  logic [6:0] m_cur;
  logic       m_four, m_two, m_disp, m_curs, m_blink, m_inc, m_low;
  logic [3:0] m_hi;
  int         clr_eff;
  int         rel_mark;

  function automatic int cell_of(input logic [6:0] a);
    return (a[6] ? 16 : 0) + int'(a[3:0]);
  endfunction

  function automatic logic [6:0] m_step(input logic [6:0] a, input logic inc);
    int p;
    p = cell_of(a);
    p = inc ? (p + 1) % 32 : (p + 31) % 32;
    return 7'((p / 16) * 64 + (p % 16));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_cells[i] = 8'h20;
    m_cur = 7'h00; m_four = 0; m_two = 0; m_disp = 0; m_curs = 0; m_blink = 0;
    m_inc = 1; m_low = 0; m_hi = 4'h0; clr_eff = -1000;
  endtask

  task automatic model_apply(input logic r, input logic [7:0] b, input int eff,
                             output logic addr_err);
    int msb;
    addr_err = 1'b0;
    msb = -1;
    for (int i = 0; i < 8; i++) if (b[i]) msb = i;
    if (r) begin
      m_cells[cell_of(m_cur)] = b;
      m_cur = m_step(m_cur, m_inc);
    end else begin
      case (msb)
        0: begin
          for (int i = 0; i < 32; i++) m_cells[i] = 8'h20;
          m_cur = 7'h00; m_inc = 1; clr_eff = eff;
        end
        1: m_cur = 7'h00;
        2: m_inc = b[1];
        3: {m_disp, m_curs, m_blink} = b[2:0];
        4: if (!b[3]) m_cur = m_step(m_cur, b[2]);
        5: begin
          if (m_four == b[4]) m_low = 0;
          m_four = !b[4];
          m_two  = b[3];
        end
        7: begin
          addr_err = (b[5:4] != 2'b00);
          m_cur = 7'((b[6] ? 64 : 0) + int'(b[3:0]));
        end
        default: ;
      endcase
    end
  endtask

  // Starts at a negedge, one enable pulse, checks once the effect is visible.
  task automatic strobe(input logic r, input logic [3:0] d);
    logic       x_valid, x_timing, x_busy, x_addr, x_busy_out;
    logic [7:0] b;
    int         eff;
    x_valid = 0; x_timing = 0; x_busy = 0; x_addr = 0; b = 8'h00;
    bus.en = 1'b1; bus.rs = r; bus.data = d;
    @(negedge clk);
    bus.en = 1'b0;
    eff = cyc + LAT;
    if (eff - rel_mark <= PU) begin
      x_timing = 1;
    end else if (m_four && !m_low) begin
      m_hi = d; m_low = 1;
    end else begin
      b = m_four ? {m_hi, d} : {d, 4'h0};
      m_low = 0; x_valid = 1;
      if (eff - clr_eff <= CB) x_busy = 1;
      else model_apply(r, b, eff, x_addr);
    end
    x_busy_out = (eff - clr_eff < CB);
    repeat (LAT) @(negedge clk);
    vectors++;
    if (byte_valid !== x_valid) begin
      miscompares++; $display("FAIL byte_valid: got %b expected %b", byte_valid, x_valid);
    end
    vectors++;
    if (err_timing !== x_timing) begin
      miscompares++; $display("FAIL err_timing: got %b expected %b", err_timing, x_timing);
    end
    vectors++;
    if (err_busy !== x_busy) begin
      miscompares++; $display("FAIL err_busy: got %b expected %b", err_busy, x_busy);
    end
    vectors++;
    if (err_addr !== x_addr) begin
      miscompares++; $display("FAIL err_addr: got %b expected %b", err_addr, x_addr);
    end
    vectors++;
    if (busy !== x_busy_out) begin
      miscompares++; $display("FAIL busy: got %b expected %b", busy, x_busy_out);
    end
    vectors++;
    if (cursor_addr !== m_cur) begin
      miscompares++; $display("FAIL cursor_addr: got %h expected %h", cursor_addr, m_cur);
    end
    vectors++;
    if ({four_bit, two_line, disp_on, cursor_on, blink_on} !== {m_four, m_two, m_disp, m_curs, m_blink}) begin
      miscompares++;
      $display("FAIL mode_flags: got %b expected %b", {four_bit, two_line, disp_on, cursor_on, blink_on},
               {m_four, m_two, m_disp, m_curs, m_blink});
    end
    if (x_valid) begin
      vectors++;
      if ({byte_rs, byte_data} !== {r, b}) begin
        miscompares++; $display("FAIL byte_out: got %b/%h expected %b/%h", byte_rs, byte_data, r, b);
      end
    end
  endtask

  task automatic send_byte(input logic r, input logic [7:0] b);
    if (m_four) begin
      strobe(r, b[7:4]);
      strobe(r, b[3:0]);
    end else begin
      strobe(r, b[7:4]);
    end
  endtask

  task automatic check_cells();
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      @(negedge clk);
      vectors++;
      if (rd_data !== m_cells[i]) begin
        miscompares++; $display("FAIL cell[%0d]: got %h expected %h", i, rd_data, m_cells[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.en = 1'b0;
    @(negedge clk);
    model_reset();
    vectors++;
    if ({rd_data, cursor_addr} !== 15'h0) begin
      miscompares++; $display("FAIL reset_data: got %h/%h expected 00/00", rd_data, cursor_addr);
    end
    vectors++;
    if ({four_bit, two_line, disp_on, cursor_on, blink_on, busy} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 000000", {four_bit, two_line, disp_on, cursor_on, blink_on, busy});
    end
    vectors++;
    if ({byte_valid, err_timing, err_busy, err_addr} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_pulses: got %b expected 0000", {byte_valid, err_timing, err_busy, err_addr});
    end
    @(negedge clk);
    reset_n = 1'b1;
    rel_mark = cyc;
  endtask

  task automatic test_powerup();
    repeat (9) @(negedge clk);
    strobe(1'b0, 4'h3);
    repeat (PU + 5) @(negedge clk);
    check_cells();
  endtask

  task automatic test_init();
    int n;
    strobe(1'b0, 4'h3); strobe(1'b0, 4'h3); strobe(1'b0, 4'h3); strobe(1'b0, 4'h2);
    send_byte(1'b0, 8'h28); send_byte(1'b0, 8'h0C); send_byte(1'b0, 8'h06); send_byte(1'b0, 8'h01);
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    vectors++;
    if (n !== CB) begin
      miscompares++; $display("FAIL busy_length: got %0d expected %0d", n, CB);
    end
    check_cells();
  endtask

  task automatic test_text();
    string s;
    s = "Its Tapeout Time";
    for (int i = 0; i < s.len(); i++) send_byte(1'b1, s[i]);
    check_cells();
  endtask

  task automatic test_clock();
    string s;
    s = "00:00:00";
    send_byte(1'b0, 8'hC4);
    for (int i = 0; i < s.len(); i++) send_byte(1'b1, s[i]);
    check_cells();
  endtask

  task automatic test_busy();
    send_byte(1'b0, 8'h01);
    send_byte(1'b1, 8'h58);
    check_cells();
  endtask

  task automatic test_decrement_and_reset();
    send_byte(1'b0, 8'h04);
    send_byte(1'b0, 8'h80);
    send_byte(1'b1, 8'h41);
    check_cells();
    strobe(1'b1, 4'h4);
    test_reset();
    repeat (PU + 5) @(negedge clk);
    strobe(1'b0, 4'h2);
    send_byte(1'b1, 8'h51);
    check_cells();
  endtask

  task automatic test_random();
    logic       r;
    logic [7:0] b;
    repeat (150) begin
      r = 1'($urandom_range(0, 1));
      b = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(r, b);
    end
    check_cells();
  endtask

  initial begin
    reset_n = 1'b0;
    bus.en = 1'b0; bus.rs = 1'b0; bus.data = 4'h0;
    rd_addr = 5'd0;
    rel_mark = 0;
    model_reset();
    repeat (3) @(negedge clk);
    test_reset();
    test_powerup();
    test_init();
    test_text();
    test_clock();
    test_busy();
    test_decrement_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd_responder.md
LCD_RESPONDER -- requirements
Module: lcd_responder

Interface
REQ-001 SHALL have parameter POWERUP_CYCLES, default 40, giving cycles after reset during which strobes are illegal.
REQ-002 SHALL have parameter CLEAR_BUSY, default 2, giving busy cycles after a clear-display command.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  HD44780 enable strobe from the driver.
REQ-006 rs  input  1  register select: 0 command, 1 data.
REQ-007 data  input  4  DB7..DB4 nibble.
REQ-008 rd_addr  input  5  DDRAM cell index for readback: bit4 line, bits3:0 column.
REQ-009 rd_data  output  8  cell contents, registered, 1-cycle latency.
REQ-010 cursor_addr  output  7  current HD44780 DDRAM address.
REQ-011 four_bit, two_line, disp_on, cursor_on, blink_on  output  1 each  decoded mode flags.
REQ-012 busy  output  1  clear in progress.
REQ-013 byte_valid  output  1  one-cycle pulse per assembled byte; byte_rs/byte_data (1/8) valid with it.
REQ-014 err_timing, err_busy, err_addr  output  1 each  one-cycle violation pulses.

Function
REQ-015 Strobe = en high one cycle, low the next; nibble and rs SHALL be taken in the cycle en is first seen low.
REQ-016 8-bit mode (four_bit=0): each strobe SHALL form byte {data,4'h0}.
REQ-017 4-bit mode: first strobe = high nibble, second = low nibble; byte completes on second; phase flag toggles per strobe.
REQ-018 Strobe while powerup counter nonzero SHALL pulse err_timing and be discarded.
REQ-019 Byte completing while busy=1 SHALL pulse err_busy and be discarded (byte_valid still pulses).
REQ-020 Command decode by highest set bit: 0x01 clear; 0x02-0x03 home; 0x04-0x07 entry mode (bit1 = I/D); 0x08-0x0F display ctrl (bits 2/1/0 = disp/cursor/blink); 0x10-0x1F shift (bit3=0 moves cursor, bit2 = right; bit3=1 ignored); 0x20-0x3F function set (bit4=0 -> four_bit=1, bit3 -> two_line); 0x40-0x7F CGRAM set, ignored; 0x80-0xFF cursor_addr <= byte[6:0].
REQ-021 Function set changing DL SHALL reset nibble phase to high.
REQ-022 Clear SHALL write 0x20 to all 32 cells in one cycle, cursor_addr=0, I/D=1, busy=1 for CLEAR_BUSY cycles.
REQ-023 Home SHALL set cursor_addr=0, DDRAM unchanged, no busy.
REQ-024 Data byte SHALL write cell {cursor_addr[6],cursor_addr[3:0]} then step cursor per I/D.
REQ-025 Increment wrap: 0x0F->0x40, 0x4F->0x00; decrement wrap: 0x00->0x4F, 0x40->0x0F; same rule for shift command.
REQ-026 DDRAM address set with byte[5:4]!=0 SHALL pulse err_addr and store {byte[6],2'b00,byte[3:0]}.
REQ-027 Simultaneous busy expiry and byte completion: byte accepted.

Reset
REQ-028 On reset_n low: four_bit=0, phase=high, two_line=0, disp_on=0, cursor_on=0, blink_on=0, I/D=1, cursor_addr=0, busy=0, all pulses 0, rd_data=0, powerup counter=POWERUP_CYCLES, all cells 0x20.
REQ-029 Reset mid-byte SHALL discard the pending high nibble.

Configuration
REQ-030 Macro LCD_RESPONDER_SYNC_EN defined: en, rs, data pass a two-flop synchronizer, adding exactly 2 cycles to all strobe-to-effect latencies; undefined: used directly, byte effects visible 1 cycle after en-low cycle.

Structure
REQ-031 Package lcd_pkg SHALL hold command opcode constants, LINE0_BASE=0x00, LINE1_BASE=0x40, blank char 0x20, and the flag struct type.
REQ-032 Sub-module lcd_resp_nibble SHALL contain sync, edge detect and nibble/byte assembly; top holds decode, DDRAM, busy and powerup counters.

Verification
REQ-033 Strobe at cycle 10 after reset -> err_timing=1, no state change.
REQ-034 After 40 cycles: nibbles 3,3,3,2 then bytes 0x28,0x0C,0x06,0x01 -> four_bit=1, two_line=1, disp_on=1, cursor_on=0, busy for 2 cycles, all cells 0x20, cursor 0x00.
REQ-035 Then 16 data bytes "Its Tapeout Time" -> cells 0-15 match, cursor_addr=0x40.
REQ-036 0xC4 then "00:00:00" -> cells 20-27 hold text, cursor_addr=0x4C.
REQ-037 0x01 immediately followed by data 'X' -> err_busy=1, no cell holds 'X'.
REQ-038 0x04, 0x80, 'A' -> cell 0='A', cursor_addr=0x4F; reset after next high nibble -> four_bit=0, phase=high.
